// File: rtl/maria_timing_pkg.sv
// Shared types and default constants for the Maria timing / CPU bus gate path.
package maria_timing_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    WRITE_DRAIN = 2'd1,
    STALLED     = 2'd2
  } gate_state_t;

  localparam int DEF_MAX_WRITE_RUN   = 3;
  localparam int DEF_NMI_HOLD_CYCLES = 2;
  localparam int DEF_STALL_CTR_W     = 8;

endpackage

// File: rtl/cpu_bus_gate_nmi_stretch.sv
// Stretches a sampled int_b fall into an NMI pulse of NMI_HOLD_CYCLES CPU cycles.
// Output registered, changes one sysclk after the sampling edge; no backpressure.
module nmi_stretch
#(
  parameter int NMI_HOLD_CYCLES = 2
) (
  input  logic sysclk,
  input  logic reset_n,
  input  logic pclk_edge,
  input  logic int_b,
  output logic cpu_nmi_n
);

  localparam int CW = $clog2(NMI_HOLD_CYCLES + 1);

  logic          int_prev;
  logic [CW-1:0] nmi_ctr;
  logic [CW-1:0] nmi_ctr_nxt;

  // A fresh fall reloads the hold, so back-to-back DLIs extend the pulse.
  always_comb begin
    nmi_ctr_nxt = nmi_ctr;
    if (pclk_edge) begin
      if (int_prev && !int_b) begin
        nmi_ctr_nxt = CW'(NMI_HOLD_CYCLES);
      end else if (nmi_ctr != '0) begin
        nmi_ctr_nxt = nmi_ctr - CW'(1);
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      int_prev  <= 1'b1;
      nmi_ctr   <= '0;
      cpu_nmi_n <= 1'b1;
    end else begin
      if (pclk_edge) begin
        int_prev <= int_b;
      end
      nmi_ctr   <= nmi_ctr_nxt;
      cpu_nmi_n <= (nmi_ctr_nxt == '0);
    end
  end

endmodule

// File: rtl/cpu_bus_gate.sv
// Maps Maria halt_b/ready/int_b onto 6502 CE, RDY, NMI and bus grant; stops only on reads.
// Outputs registered on the pclk_0 rising-edge sysclk; writes drain up to MAX_WRITE_RUN first.
module cpu_bus_gate
  import maria_timing_pkg::*;
#(
  parameter int MAX_WRITE_RUN   = DEF_MAX_WRITE_RUN,
  parameter int NMI_HOLD_CYCLES = DEF_NMI_HOLD_CYCLES,
  parameter int STALL_CTR_W     = DEF_STALL_CTR_W
) (
  input  logic                   sysclk,
  input  logic                   reset_n,
  input  logic                   pclk_0,
  input  logic                   halt_b,
  input  logic                   ready,
  input  logic                   int_b,
  input  logic                   cpu_rw,
  output logic                   cpu_ce,
  output logic                   cpu_rdy,
  output logic                   cpu_nmi_n,
  output logic                   bus_grant,
  output logic                   halt_ack,
  output logic                   halt_err,
  output logic [STALL_CTR_W-1:0] stall_cycles
);

  localparam int WR_W = $clog2(MAX_WRITE_RUN + 1);

  gate_state_t     state;
  gate_state_t     state_nxt;
  logic [WR_W-1:0] wr_cnt;
  logic [WR_W-1:0] wr_cnt_nxt;
  logic            pclk_prev;
  logic            pclk_rise;
  logic            stop_req;
  logic            halt_err_set;
  logic            enter_stall;
  logic            grant_nxt;

  assign pclk_rise   = pclk_0 & ~pclk_prev;
  assign stop_req    = ~halt_b | ~ready;
  assign enter_stall = pclk_rise && (state != STALLED) && (state_nxt == STALLED);
  assign grant_nxt   = (state_nxt == STALLED) & ~halt_b;

  always_comb begin
    state_nxt    = state;
    wr_cnt_nxt   = wr_cnt;
    halt_err_set = 1'b0;
    if (pclk_rise) begin
      case (state)
        RUN: begin
          if (stop_req) begin
            if (cpu_rw) begin
              state_nxt = STALLED;
            end else begin
              state_nxt  = WRITE_DRAIN;
              wr_cnt_nxt = WR_W'(1);
            end
          end
        end
        WRITE_DRAIN: begin
          if (!stop_req) begin
            state_nxt = RUN;
          end else if (cpu_rw) begin
            state_nxt = STALLED;
          end else if (wr_cnt == WR_W'(MAX_WRITE_RUN)) begin
            // Write run too long: stop the CPU mid-write and flag it.
            state_nxt    = STALLED;
            halt_err_set = 1'b1;
          end else begin
            wr_cnt_nxt = wr_cnt + WR_W'(1);
          end
        end
        STALLED: begin
          if (halt_b && ready) begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      wr_cnt       <= '0;
      pclk_prev    <= 1'b1;
      cpu_ce       <= 1'b0;
      cpu_rdy      <= 1'b1;
      bus_grant    <= 1'b0;
      halt_ack     <= 1'b0;
      halt_err     <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state     <= state_nxt;
      wr_cnt    <= wr_cnt_nxt;
      pclk_prev <= pclk_0;
      cpu_ce    <= pclk_rise;
      cpu_rdy   <= (state_nxt != STALLED);
      if (halt_err_set) begin
        halt_err <= 1'b1;
      end
      if (pclk_rise) begin
        bus_grant <= grant_nxt;
        halt_ack  <= grant_nxt;
      end
      if (enter_stall) begin
        stall_cycles <= '0;
      end else if (pclk_rise && (state == STALLED) && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + STALL_CTR_W'(1);
      end
    end
  end

  nmi_stretch #(
    .NMI_HOLD_CYCLES(NMI_HOLD_CYCLES)
  ) u_nmi_stretch (
    .sysclk    (sysclk),
    .reset_n   (reset_n),
    .pclk_edge (pclk_rise),
    .int_b     (int_b),
    .cpu_nmi_n (cpu_nmi_n)
  );

endmodule
